// File: rtl/alu_cmd_sched.sv
// alu_cmd_sched: buffers tagged ALU commands, issues them one at a time and returns tagged results with a watchdog
module alu_cmd_sched #(
   parameter int DEPTH   = 4,
   parameter int TAG_W   = 4,
   parameter int TIMEOUT = 64
) (
   input  logic                       sys_clk,
   input  logic                       sys_rst,
   input  logic                       cmd_valid,
   output logic                       cmd_ready,
   input  logic [1:0]                 cmd_op,
   input  logic [31:0]                cmd_a,
   input  logic [31:0]                cmd_b,
   input  logic [TAG_W-1:0]           cmd_tag,
   output logic                       alu_trig,
   output logic [1:0]                 alu_op,
   output logic [31:0]                alu_data1,
   output logic [31:0]                alu_data2,
   input  logic                       alu_work,
   input  logic                       alu_vld,
   input  logic [31:0]                alu_result,
   output logic                       res_valid,
   input  logic                       res_ready,
   output logic [31:0]                res_data,
   output logic [TAG_W-1:0]           res_tag,
   output logic                       res_err,
   output logic [$clog2(DEPTH):0]     fifo_level
);
   localparam int AW = $clog2(DEPTH);
   localparam int EW = 66 + TAG_W;
   localparam int TW = $clog2(TIMEOUT);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
   state_t state;
   logic [EW-1:0] mem [DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr;
   logic [AW:0] count;
   logic [TW-1:0] timer;
   logic [EW-1:0] head;
   logic push, pop, timeout;
   assign cmd_ready = count != (AW+1)'(DEPTH);
   assign push = cmd_valid && cmd_ready;
   // an empty FIFO forwards the incoming command so it can issue the cycle after it is accepted
   assign head = (count == '0) ? {cmd_op, cmd_a, cmd_b, cmd_tag} : mem[rd_ptr];
   assign timeout = timer == TW'(TIMEOUT - 1);
   assign pop = (state == WAIT) && (alu_vld || timeout);
   assign fifo_level = count;
   always_ff @(posedge sys_clk)
      if (push) mem[wr_ptr] <= {cmd_op, cmd_a, cmd_b, cmd_tag};
   always_ff @(posedge sys_clk or posedge sys_rst)
      if (sys_rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + (AW+1)'(push) - (AW+1)'(pop);
      end
   always_ff @(posedge sys_clk or posedge sys_rst)
      if (sys_rst) begin
         state     <= IDLE;
         timer     <= '0;
         alu_trig  <= 1'b0;
         alu_op    <= '0;
         alu_data1 <= '0;
         alu_data2 <= '0;
         res_valid <= 1'b0;
         res_data  <= '0;
         res_tag   <= '0;
         res_err   <= 1'b0;
      end else begin
         case (state)
            IDLE:
               if ((count != '0 || push) && !alu_work) begin
                  state <= ISSUE;
                  alu_trig <= 1'b1;
                  {alu_op, alu_data1, alu_data2} <= head[EW-1:TAG_W];
               end
            ISSUE: begin
               state <= WAIT;
               alu_trig <= 1'b0;
               timer <= '0;
            end
            WAIT:
               if (pop) begin
                  state <= DONE;
                  {alu_op, alu_data1, alu_data2} <= '0;
                  res_valid <= 1'b1;
                  res_data <= alu_vld ? alu_result : 32'h7FC0_0000;
                  res_err <= !alu_vld;
                  res_tag <= head[TAG_W-1:0];
               end else
                  timer <= timer + 1'b1;
            DONE:
               if (res_ready) begin
                  state <= IDLE;
                  res_valid <= 1'b0;
               end
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_alu_cmd_sched.sv
// tb_alu_cmd_sched: scoreboard bench with a behavioural ALU model driving the scheduler
module tb_alu_cmd_sched;
   localparam int TO = 16;
   typedef struct {
      logic [3:0]  tag;
      logic [31:0] data;
      logic        err;
   } exp_t;
   logic sys_clk = 1'b0, sys_rst = 1'b1;
   logic cmd_valid = 1'b0, cmd_ready;
   logic [1:0] cmd_op = '0;
   logic [31:0] cmd_a = '0, cmd_b = '0;
   logic [3:0] cmd_tag = '0;
   logic alu_trig, alu_work, alu_vld;
   logic [1:0] alu_op;
   logic [31:0] alu_data1, alu_data2, alu_result;
   logic res_valid, res_ready = 1'b0, res_err;
   logic [31:0] res_data;
   logic [3:0] res_tag;
   logic [2:0] fifo_level;
   exp_t sb[$];
   exp_t e;
   int total = 0, bad = 0;
   int alu_lat = 6, cnt = 0;
   bit mute = 0, busy = 0;
   logic hold_work = 1'b0, inj_vld = 1'b0, model_vld = 1'b0;
   logic [31:0] inj_res = '0, model_res = '0, m_a = '0, m_b = '0;
   logic [1:0] m_op = '0;
   assign alu_work = busy | hold_work;
   assign alu_vld = model_vld | inj_vld;
   assign alu_result = inj_vld ? inj_res : model_res;
   alu_cmd_sched #(.DEPTH(4), .TAG_W(4), .TIMEOUT(TO)) dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
      .alu_trig(alu_trig), .alu_op(alu_op), .alu_data1(alu_data1), .alu_data2(alu_data2),
      .alu_work(alu_work), .alu_vld(alu_vld), .alu_result(alu_result),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_tag(res_tag), .res_err(res_err),
      .fifo_level(fifo_level)
   );
   always #5 sys_clk = ~sys_clk;
   function automatic logic [31:0] fake_alu(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      return (op == 2'd0 && a == 32'h3F80_0000 && b == 32'h4000_0000) ? 32'h4040_0000 :
             a ^ {b[15:0], b[31:16]} ^ {30'd0, op};
   endfunction
   // ALU model: answers alu_lat negedges after seeing trig, unless muted
   always @(negedge sys_clk) begin
      model_vld = 1'b0;
      if (sys_rst) busy = 0;
      else if (busy) begin
         cnt--;
         if (cnt == 0) begin
            model_vld = 1'b1;
            model_res = fake_alu(m_op, m_a, m_b);
            busy = 0;
         end
      end else if (alu_trig && !mute) begin
         busy = 1;
         cnt = alu_lat;
         m_op = alu_op;
         m_a = alu_data1;
         m_b = alu_data2;
      end
   end
   always @(negedge sys_clk)
      if (!sys_rst && res_valid && res_ready) begin
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL unexpected_result: got tag=%0d data=%h err=%b, required no result", res_tag, res_data, res_err);
         end else begin
            e = sb.pop_front();
            if ({res_tag, res_data, res_err} !== {e.tag, e.data, e.err}) begin
               bad++;
               $display("FAIL result: got tag=%0d data=%h err=%b, required tag=%0d data=%h err=%b",
                        res_tag, res_data, res_err, e.tag, e.data, e.err);
            end
         end
      end
   task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag,
                       input logic [31:0] d, input logic err, input int max_wait, output bit ok);
      cmd_valid = 1'b1;
      cmd_op = op;
      cmd_a = a;
      cmd_b = b;
      cmd_tag = tag;
      ok = 0;
      for (int n = 0; n < max_wait && !ok; n++) begin
         if (cmd_ready) begin
            sb.push_back('{tag, d, err});
            ok = 1;
         end
         @(negedge sys_clk);
      end
      cmd_valid = 1'b0;
   endtask
   task automatic drain(input int max_cycles);
      for (int n = 0; n < max_cycles && sb.size() != 0; n++) @(negedge sys_clk);
   endtask
   task automatic test_reset;
      sys_rst = 1'b1;
      repeat (2) @(negedge sys_clk);
      total++;
      if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready: got %b, required 1", cmd_ready); end
      total++;
      if ({alu_trig, alu_op, alu_data1, alu_data2} !== 67'd0) begin
         bad++; $display("FAIL reset_alu: got trig=%b op=%h d1=%h d2=%h, required all 0", alu_trig, alu_op, alu_data1, alu_data2);
      end
      total++;
      if ({res_valid, res_data, res_tag, res_err} !== 38'd0) begin
         bad++; $display("FAIL reset_res: got v=%b d=%h t=%h e=%b, required all 0", res_valid, res_data, res_tag, res_err);
      end
      total++;
      if (fifo_level !== 3'd0) begin bad++; $display("FAIL reset_level: got %0d, required 0", fifo_level); end
      sys_rst = 1'b0;
      @(negedge sys_clk);
   endtask
   task automatic test_single_add;
      bit ok;
      int lat, trigs;
      res_ready = 1'b1;
      alu_lat = 6;
      send(2'd0, 32'h3F80_0000, 32'h4000_0000, 4'd5, 32'h4040_0000, 1'b0, 4, ok);
      total++;
      if (!ok || alu_trig !== 1'b1 || fifo_level !== 3'd1) begin
         bad++; $display("FAIL add_issue: got ok=%0d trig=%b level=%0d, required 1 1 1", ok, alu_trig, fifo_level);
      end
      @(negedge sys_clk);
      total++;
      if (alu_trig !== 1'b0 || alu_data1 !== 32'h3F80_0000 || alu_data2 !== 32'h4000_0000 || alu_op !== 2'd0) begin
         bad++; $display("FAIL add_hold: got trig=%b d1=%h d2=%h, required 0 3f800000 40000000", alu_trig, alu_data1, alu_data2);
      end
      lat = 1;
      trigs = 0;
      for (int n = 0; n < 40 && !res_valid; n++) begin
         @(negedge sys_clk);
         lat++;
         if (alu_trig) trigs++;
      end
      total++;
      if (lat != alu_lat + 1 || trigs != 0) begin
         bad++; $display("FAIL add_latency: got %0d cycles %0d extra trigs, required %0d cycles 0 trigs", lat, trigs, alu_lat + 1);
      end
      total++;
      if (fifo_level !== 3'd0 || alu_data1 !== 32'd0) begin
         bad++; $display("FAIL add_done: got level=%0d d1=%h, required 0 0", fifo_level, alu_data1);
      end
      drain(20);
      total++;
      if (sb.size() != 0) begin bad++; $display("FAIL add_drain: got %0d pending, required 0", sb.size()); end
   endtask
   task automatic test_fill;
      bit ok;
      logic [31:0] a, b;
      res_ready = 1'b0;
      hold_work = 1'b1;
      alu_lat = 2;
      for (int i = 0; i < 5; i++) begin
         a = 32'h1000_0000 + i;
         b = 32'h0000_00F0 << i;
         if (i == 4) begin
            send(2'(i), a, b, 4'(i), fake_alu(2'(i), a, b), 1'b0, 3, ok);
            total++;
            if (ok || cmd_ready !== 1'b0 || fifo_level !== 3'd4) begin
               bad++; $display("FAIL fill_full: got accepted=%0d ready=%b level=%0d, required 0 0 4", ok, cmd_ready, fifo_level);
            end
            hold_work = 1'b0;
            res_ready = 1'b1;
            send(2'(i), a, b, 4'(i), fake_alu(2'(i), a, b), 1'b0, 60, ok);
            total++;
            if (!ok || fifo_level !== 3'd4) begin
               bad++; $display("FAIL fill_after_pop: got accepted=%0d level=%0d, required 1 4", ok, fifo_level);
            end
         end else begin
            send(2'(i), a, b, 4'(i), fake_alu(2'(i), a, b), 1'b0, 1, ok);
            total++;
            if (!ok) begin bad++; $display("FAIL fill_accept: got not accepted tag %0d, required accepted", i); end
         end
      end
      drain(200);
      total++;
      if (sb.size() != 0) begin bad++; $display("FAIL fill_drain: got %0d pending, required 0", sb.size()); end
   endtask
   task automatic test_backpressure;
      bit ok;
      logic [36:0] snap;
      res_ready = 1'b0;
      alu_lat = 3;
      send(2'd1, 32'h4120_0000, 32'hC0A0_0000, 4'd7, fake_alu(2'd1, 32'h4120_0000, 32'hC0A0_0000), 1'b0, 4, ok);
      send(2'd2, 32'h0000_1234, 32'h8765_0000, 4'd8, fake_alu(2'd2, 32'h0000_1234, 32'h8765_0000), 1'b0, 4, ok);
      for (int n = 0; n < 40 && !res_valid; n++) @(negedge sys_clk);
      total++;
      if (res_valid !== 1'b1) begin bad++; $display("FAIL bp_result: got res_valid=%b, required 1", res_valid); end
      snap = {res_data, res_tag, res_err};
      for (int n = 0; n < 20; n++) begin
         inj_vld = (n % 3 == 0);
         inj_res = 32'hDEAD_BEEF;
         @(negedge sys_clk);
         total++;
         if (res_valid !== 1'b1 || {res_data, res_tag, res_err} !== snap || alu_trig !== 1'b0) begin
            bad++; $display("FAIL bp_hold: got v=%b d=%h t=%0d trig=%b, required v=1 d=%h t=%0d trig=0",
                            res_valid, res_data, res_tag, alu_trig, snap[36:5], snap[4:1]);
         end
      end
      inj_vld = 1'b0;
      total++;
      if (fifo_level !== 3'd1) begin bad++; $display("FAIL bp_level: got %0d, required 1", fifo_level); end
      res_ready = 1'b1;
      drain(60);
      total++;
      if (sb.size() != 0) begin bad++; $display("FAIL bp_drain: got %0d pending, required 0", sb.size()); end
   endtask
   task automatic test_timeout;
      bit ok, seen;
      int lat;
      mute = 1;
      res_ready = 1'b1;
      send(2'd3, 32'h7F80_0000, 32'hFF80_0000, 4'd9, 32'h7FC0_0000, 1'b1, 4, ok);
      lat = 0;
      for (int n = 0; n < TO + 20 && !res_valid; n++) begin
         @(negedge sys_clk);
         lat++;
      end
      total++;
      if (lat != TO + 1) begin bad++; $display("FAIL timeout_latency: got %0d cycles, required %0d", lat, TO + 1); end
      @(negedge sys_clk);
      inj_vld = 1'b1;
      inj_res = 32'h1234_5678;
      @(negedge sys_clk);
      inj_vld = 1'b0;
      seen = 0;
      for (int n = 0; n < 10; n++) begin
         if (res_valid || alu_trig) seen = 1;
         @(negedge sys_clk);
      end
      total++;
      if (seen || fifo_level !== 3'd0) begin
         bad++; $display("FAIL timeout_late_vld: got activity=%0d level=%0d, required 0 0", seen, fifo_level);
      end
      total++;
      if (sb.size() != 0) begin bad++; $display("FAIL timeout_drain: got %0d pending, required 0", sb.size()); end
   endtask
   task automatic test_tie;
      bit ok;
      mute = 1;
      res_ready = 1'b1;
      send(2'd0, 32'h3F80_0000, 32'h3F80_0000, 4'd10, 32'hA5A5_5A5A, 1'b0, 4, ok);
      repeat (TO - 1) @(negedge sys_clk);
      total++;
      if (res_valid !== 1'b0) begin bad++; $display("FAIL tie_early: got res_valid=%b, required 0", res_valid); end
      @(negedge sys_clk);
      inj_vld = 1'b1;
      inj_res = 32'hA5A5_5A5A;
      @(negedge sys_clk);
      inj_vld = 1'b0;
      drain(10);
      total++;
      if (sb.size() != 0) begin bad++; $display("FAIL tie_drain: got %0d pending, required 0", sb.size()); end
      mute = 0;
   endtask
   task automatic test_reset_mid_wait;
      bit ok, seen;
      mute = 1;
      res_ready = 1'b1;
      for (int i = 0; i < 3; i++)
         send(2'(i), 32'h4000_0000 + i, 32'h4080_0000, 4'(11 + i), 32'h0, 1'b0, 4, ok);
      repeat (2) @(negedge sys_clk);
      total++;
      if (fifo_level !== 3'd3 || res_valid !== 1'b0) begin
         bad++; $display("FAIL rst_pre: got level=%0d v=%b, required 3 0", fifo_level, res_valid);
      end
      sys_rst = 1'b1;
      #1;
      total++;
      if ({alu_trig, alu_op, alu_data1, alu_data2, res_valid, res_data, res_tag, res_err} !== 105'd0 ||
          fifo_level !== 3'd0 || cmd_ready !== 1'b1) begin
         bad++; $display("FAIL rst_mid_wait: got trig=%b d1=%h v=%b level=%0d ready=%b, required 0 0 0 0 1",
                         alu_trig, alu_data1, res_valid, fifo_level, cmd_ready);
      end
      sb.delete();
      @(negedge sys_clk);
      sys_rst = 1'b0;
      mute = 0;
      seen = 0;
      for (int n = 0; n < 30; n++) begin
         @(negedge sys_clk);
         if (res_valid || alu_trig) seen = 1;
      end
      total++;
      if (seen) begin bad++; $display("FAIL rst_after: got activity after reset, required none"); end
   endtask
   initial begin
      test_reset;
      test_single_add;
      test_fill;
      test_backpressure;
      test_timeout;
      test_tie;
      test_reset_mid_wait;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/alu_cmd_sched.md
# alu_cmd_sched

Command front-end for the IEEE-754 single-precision ALU top level. It accepts tagged operation requests over a valid/ready interface and buffers them in a small FIFO. Commands are issued one at a time to the ALU's `trig`/`opcode`/`data_in1`/`data_in2` inputs, and the ALU result is captured on `vld`. Each result is returned with its tag over a second valid/ready interface. A watchdog returns an error result if the ALU never answers.

## Interface
Parameters:
- `DEPTH`, 4: command FIFO entries; power of 2, ≥2.
- `TAG_W`, 4: width of the caller tag carried with each command.
- `TIMEOUT`, 64: max cycles in WAIT before an error result is forced; ≥2.

Ports:
- `sys_clk` in 1: clock; all logic on its rising edge.
- `sys_rst` in 1: reset, asynchronous, active-high.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: FIFO can accept.
- `cmd_op` in 2: ALU opcode, passed through unchanged.
- `cmd_a` in 32: operand 1 (IEEE-754 single).
- `cmd_b` in 32: operand 2.
- `cmd_tag` in TAG_W: caller tag.
- `alu_trig` out 1: one-cycle issue pulse to ALU `trig`.
- `alu_op` out 2: to ALU `opcode`.
- `alu_data1` out 32: to ALU `data_in1`.
- `alu_data2` out 32: to ALU `data_in2`.
- `alu_work` in 1: ALU busy, from ALU `work`.
- `alu_vld` in 1: ALU result valid, from ALU `vld`.
- `alu_result` in 32: from ALU `data_out`.
- `res_valid` out 1: result present.
- `res_ready` in 1: consumer accepts.
- `res_data` out 32: result.
- `res_tag` out TAG_W: tag of the originating command.
- `res_err` out 1: 1 = watchdog timeout.
- `fifo_level` out $clog2(DEPTH)+1: current FIFO occupancy.

## Operation
- FIFO storage: `{op, a, b, tag}` per entry, with a wrap-around read pointer and write pointer of log2(DEPTH) bits plus a count.
- Push: when `cmd_valid && cmd_ready`.
- `cmd_ready` = `count < DEPTH`. It is registered-state based and does not look ahead to a same-cycle pop.
- Pop: the head is removed when its result (normal or error) is captured. It stays at the head throughout IDLE→ISSUE→WAIT.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- The block never interprets operands or opcodes.

FSM states and transitions:
- IDLE → ISSUE when count ≠ 0 and `alu_work` = 0.
- ISSUE: `alu_trig` = 1 for exactly this cycle → WAIT; timer cleared to 0.
- WAIT:
  - On `alu_vld` = 1: capture `alu_result`, set `res_err` = 0, pop → DONE.
  - Otherwise the timer increments. When the timer reaches TIMEOUT−1 with no `alu_vld`: `res_data` = 32'h7FC0_0000 (qNaN), `res_err` = 1, pop → DONE.
  - If `alu_vld` arrives in the same cycle as the timeout, `alu_vld` wins.
- DONE: `res_valid` = 1. On `res_ready` → IDLE.

Output behaviour:
- `alu_op`/`alu_data1`/`alu_data2` are driven from the FIFO head and are held stable from ISSUE through the end of WAIT.
- In IDLE and DONE these outputs are 0.
- `alu_vld` outside WAIT (e.g. a late answer after a timeout) is ignored.
- `res_tag` = tag of the popped entry, registered with `res_data`. `res_data`/`res_tag`/`res_err` are stable while `res_valid` = 1.

## Timing
- Reset (asynchronous assert, synchronous release):
  - state IDLE, FIFO empty, timer 0.
  - Outputs: `cmd_ready` = 1 (DEPTH>0); `alu_trig`, `alu_op`, `alu_data1`, `alu_data2`, `res_valid`, `res_data`, `res_tag`, `res_err`, `fifo_level` = 0.
  - Reset during WAIT or DONE discards the in-flight and buffered commands, and no result is produced.
- Push accepted at edge N: `fifo_level` updates at N+1. If idle with `alu_work` = 0, the FSM is in ISSUE during cycle N+1 and `alu_trig` is high then.
- ALU `vld` sampled high at edge M (in WAIT): `res_valid` is high from cycle M+1. The FIFO pop is visible in `fifo_level` at M+1.
- Minimum latency from push to `res_valid` = 3 cycles plus ALU latency.
- Result handshake at edge K: `res_valid` = 0 at K+1 (IDLE). The earliest next `alu_trig` is at K+2.
- Only one command is in flight, so throughput is 1 per (ALU latency + 3) cycles.

## Test plan
- Single add: op 00, a = 32'h3F80_0000, b = 32'h4000_0000, tag 5; ALU model answers 32'h4040_0000 after 6 cycles → one `alu_trig` pulse, `res_valid` with `res_data` = 32'h4040_0000, `res_tag` = 5, `res_err` = 0.
- Fill: push 5 back-to-back with `res_ready` = 0 and ALU stalled → `cmd_ready` drops after 4 accepts and `fifo_level` = 4. Release → results emerge in tag order 0,1,2,3 and the 5th is accepted once a pop occurs.
- Backpressure: `res_ready` held 0 for 20 cycles → `res_*` stable, no new `alu_trig`, and `alu_vld` pulses injected in DONE are ignored.
- Timeout: ALU never asserts `vld` → after TIMEOUT cycles in WAIT, `res_data` = 32'h7FC0_0000, `res_err` = 1. A late `alu_vld` in IDLE produces no result.
- Timeout tie: `alu_vld` is asserted exactly in the timeout cycle → normal result, `res_err` = 0.
- Reset mid-WAIT with 3 entries queued → all outputs 0 next cycle, `fifo_level` = 0, no `res_valid` afterwards.
